// File: rtl/conv2_acc_sat.sv
// rtl/conv2_acc_sat.sv - per-pixel product accumulator with round, shift and saturate to an activation
//
// Purpose: sums TAPS signed products onto a bias (pre-scaled by SHIFT),
// then rounds half toward +inf, shifts right by SHIFT and saturates to
// OUT_W bits. The result is held in one output register until consumed.
// Optional feature macro: CONV2_ACC_RELU_EN (clamp negative results to 0).
//
// Ports:
//   ap_clk      in   clock, rising edge
//   ap_rst_n    in   asynchronous active-low reset
//   prod_data   in   signed product (PROD_W)
//   prod_valid  in   product beat valid
//   prod_last   in   final-tap marker, checked against the tap counter only
//   prod_ready  out  beat can be accepted (ACC state, not in reset)
//   bias        in   signed bias (BIAS_W), sampled on the first beat of a pixel
//   out_data    out  signed activation (OUT_W)
//   out_valid   out  out_data valid
//   out_ready   in   consumer accepts out_data
//   busy        out  a pixel is in progress
//   err         out  sticky prod_last mismatch flag
module conv2_acc_sat #(
    parameter int PROD_W = 24,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 14,
    parameter int BIAS_W = 14,
    parameter int TAPS   = 150,
    parameter int SHIFT  = 8
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [PROD_W-1:0] prod_data,
    input  logic              prod_valid,
    input  logic              prod_last,
    output logic              prod_ready,
    input  logic [BIAS_W-1:0] bias,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = $clog2(TAPS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TAPS - 1);

    // Rounding is done one bit wider than the accumulator so adding the
    // half-LSB can never wrap a near-maximum sum to a negative value.
    localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] OUT_MIN = (ACC_W+1)'(-(2 ** (OUT_W - 1)));

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_ROUND = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic        [CNT_W-1:0]  cnt_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic        [OUT_W-1:0]  out_data_q;
    logic                     out_valid_q;
    logic                     err_q;

    logic                     beat;
    logic                     last_tap;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W:0]    rnd_sum;
    logic signed [ACC_W:0]    shifted;
    logic        [OUT_W-1:0]  result;

    assign beat     = prod_valid && prod_ready;
    assign last_tap = (cnt_q == LAST_CNT);
    assign prod_ext = {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};
    assign bias_ext = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};

    // Round half toward +inf, arithmetic shift, saturate, optional ReLU.
    always_comb begin
        rnd_sum = {acc_q[ACC_W-1], acc_q} + HALF;
        shifted = rnd_sum >>> SHIFT;
        result  = '0;
        if (shifted > OUT_MAX) begin
            result = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (shifted < OUT_MIN) begin
            result = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            result = shifted[OUT_W-1:0];
        end
`ifdef CONV2_ACC_RELU_EN
        if (result[OUT_W-1]) begin
            result = '0;
        end
`else
`endif
    end

    // FSM: state register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state; the pixel closes on the counter, never on prod_last
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC:   if (beat && last_tap) state_d = ST_ROUND;
            ST_ROUND: state_d = ST_HOLD;
            ST_HOLD:  if (out_valid_q && out_ready) state_d = ST_ACC;
            default:  state_d = ST_ACC;
        endcase
    end

    // FSM: outputs
    always_comb begin
        prod_ready = ap_rst_n && (state_q == ST_ACC);
        busy       = (state_q != ST_ACC) || (cnt_q != '0);
    end

    // Datapath registers
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (beat) begin
                if (cnt_q == '0) begin
                    acc_q <= (bias_ext <<< SHIFT) + prod_ext;
                end else begin
                    acc_q <= acc_q + prod_ext;
                end
                cnt_q <= last_tap ? '0 : cnt_q + 1'b1;
                if (prod_last != last_tap) begin
                    err_q <= 1'b1;
                end
            end
            if (state_q == ST_ROUND) begin
                out_data_q  <= result;
                out_valid_q <= 1'b1;
            end else if (state_q == ST_HOLD && out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_conv2_acc_sat.sv
// tb/tb_conv2_acc_sat.sv - directed self-checking bench for conv2_acc_sat (TAPS=4, SHIFT=8)
module tb_conv2_acc_sat;

    logic        ap_clk;
    logic        ap_rst_n;
    logic [23:0] prod_data;
    logic        prod_valid;
    logic        prod_last;
    logic        prod_ready;
    logic [13:0] bias;
    logic [13:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [13:0] held;

    conv2_acc_sat #(
        .PROD_W(24), .ACC_W(32), .OUT_W(14), .BIAS_W(14), .TAPS(4), .SHIFT(8)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .prod_data  (prod_data),
        .prod_valid (prod_valid),
        .prod_last  (prod_last),
        .prod_ready (prod_ready),
        .bias       (bias),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .err        (err)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic drive_beat(input logic [23:0] d, input logic last);
        prod_valid = 1'b1;
        prod_data  = d;
        prod_last  = last;
        step();
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    // Four beats of the same product; out_valid must be low in ROUND and
    // high with the expected value one cycle later.
    task automatic run_pixel(input string tag, input logic [13:0] b, input logic [23:0] d,
                             input int gap, input logic [13:0] exp);
        bias = b;
        for (int i = 0; i < 4; i++) begin
            drive_beat(d, i == 3);
            if (i < 3) repeat (gap) step();
        end
        check({tag, "_round_valid"}, out_valid, 0);
        check({tag, "_round_busy"}, busy, 1);
        step();
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, exp);
        check({tag, "_ready_low"}, prod_ready, 0);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_hs_valid"}, out_valid, 0);
        check({tag, "_hs_ready"}, prod_ready, 1);
    endtask

    initial begin
        ap_rst_n   = 1'b0;
        prod_data  = '0;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        bias       = '0;
        out_ready  = 1'b0;
        #1;
        check("rst_ready", prod_ready, 0);
        step();
        step();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        ap_rst_n = 1'b1;
        step();
        check("post_rst_ready", prod_ready, 1);

        // Basic: (1<<8) + 4*256 = 1280 -> 5
        run_pixel("basic", 14'd1, 24'd256, 0, 14'd5);
        check("basic_err", err, 0);
        handshake("basic");

        // Saturation
        run_pixel("sat_pos", 14'd0, 24'h7FFFFF, 0, 14'd8191);
        handshake("sat_pos");
`ifdef CONV2_ACC_RELU_EN
        run_pixel("sat_neg", 14'd0, 24'h800000, 0, 14'd0);
`else
        run_pixel("sat_neg", 14'd0, 24'h800000, 0, 14'h2000);
`endif
        handshake("sat_neg");

        // Rounding, with gaps between beats
`ifdef CONV2_ACC_RELU_EN
        run_pixel("rnd_neg", 14'd0, 24'hFFFFA0, 2, 14'd0);
`else
        run_pixel("rnd_neg", 14'd0, 24'hFFFFA0, 2, 14'h3FFF);
`endif
        handshake("rnd_neg");
        run_pixel("rnd_pos", 14'd0, 24'd32, 1, 14'd1);

        // Backpressure: upstream presents a beat while the result is held
        held       = out_data;
        prod_valid = 1'b1;
        prod_data  = 24'd256;
        prod_last  = 1'b0;
        bias       = 14'd1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_data", out_data, held);
            check("bp_ready", prod_ready, 0);
            check("bp_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_hs_ready", prod_ready, 1);
        check("bp_hs_busy", busy, 0);
        step();
        check("bp_first_busy", busy, 1);
        prod_valid = 1'b0;
        for (int i = 0; i < 3; i++) drive_beat(24'd256, i == 2);
        step();
        check("bp_valid2", out_valid, 1);
        check("bp_data2", out_data, 5);
        handshake("bp");

        // prod_last on the 2nd beat and missing on the 4th
        bias = 14'd0;
        drive_beat(24'd512, 1'b0);
        check("err_beat1", err, 0);
        drive_beat(24'd512, 1'b1);
        check("err_beat2", err, 1);
        drive_beat(24'd512, 1'b0);
        drive_beat(24'd512, 1'b0);
        check("err_round_valid", out_valid, 0);
        step();
        check("err_valid", out_valid, 1);
        check("err_data", out_data, 8);
        handshake("err");
        check("err_sticky", err, 1);

        // Reset mid-pixel
        drive_beat(24'd1000, 1'b0);
        drive_beat(24'd1000, 1'b0);
        check("pre_rst_busy", busy, 1);
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_ready", prod_ready, 0);
        step();
        ap_rst_n = 1'b1;
        run_pixel("after_rst", 14'd0, 24'd512, 0, 14'd8);
        check("after_rst_err", err, 0);
        handshake("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
